// File: rtl/anthem_pkg.sv
// Shared constants and the ASCII-to-7-segment decoder for the anthem character link.
package anthem_pkg;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Segment codes: bit0=a ... bit6=g
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_G = 7'h3D;
  localparam logic [6:0] SEG_H = 7'h76;
  localparam logic [6:0] SEG_I = 7'h06;
  localparam logic [6:0] SEG_L = 7'h38;
  localparam logic [6:0] SEG_N = 7'h54;
  localparam logic [6:0] SEG_O = 7'h3F;
  localparam logic [6:0] SEG_P = 7'h73;
  localparam logic [6:0] SEG_R = 7'h50;
  localparam logic [6:0] SEG_S = 7'h6D;
  localparam logic [6:0] SEG_T = 7'h78;
  localparam logic [6:0] SEG_U = 7'h3E;
  localparam logic [6:0] SEG_Y = 7'h6E;
  localparam logic [6:0] SEG_Z = 7'h5B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SHOW = 2'd2,
    ST_GAP  = 2'd3
  } disp_state_e;

  // Lowercase is folded to uppercase; anything without a glyph shows a dash.
  function automatic logic [6:0] seg_decode(input logic [7:0] ch);
    logic [7:0] c;
    c = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    case (c)
      8'h30: seg_decode = SEG_0;
      8'h31: seg_decode = SEG_1;
      8'h32: seg_decode = SEG_2;
      8'h33: seg_decode = SEG_3;
      8'h34: seg_decode = SEG_4;
      8'h35: seg_decode = SEG_5;
      8'h36: seg_decode = SEG_6;
      8'h37: seg_decode = SEG_7;
      8'h38: seg_decode = SEG_8;
      8'h39: seg_decode = SEG_9;
      8'h41: seg_decode = SEG_A;
      8'h42: seg_decode = SEG_B;
      8'h43: seg_decode = SEG_C;
      8'h44: seg_decode = SEG_D;
      8'h45: seg_decode = SEG_E;
      8'h46: seg_decode = SEG_F;
      8'h47: seg_decode = SEG_G;
      8'h48: seg_decode = SEG_H;
      8'h49: seg_decode = SEG_I;
      8'h4C: seg_decode = SEG_L;
      8'h4E: seg_decode = SEG_N;
      8'h4F: seg_decode = SEG_O;
      8'h50: seg_decode = SEG_P;
      8'h52: seg_decode = SEG_R;
      8'h53: seg_decode = SEG_S;
      8'h54: seg_decode = SEG_T;
      8'h55: seg_decode = SEG_U;
      8'h59: seg_decode = SEG_Y;
      8'h5A: seg_decode = SEG_Z;
      ASCII_SPACE: seg_decode = SEG_BLANK;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/anthem_char_rx_display_if.sv
// Character link from the anthem transmitter: byte, strobe and back-pressure hint.
interface anthem_char_rx_display_if;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_ready;

  modport master (output rx_data, output rx_strobe, input rx_ready);
  modport slave  (input rx_data, input rx_strobe, output rx_ready);
endinterface

// File: rtl/anthem_char_fifo.sv
// Small synchronous FIFO with show-ahead read; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module anthem_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/anthem_char_rx_display.sv
// Receives strobed ASCII bytes, buffers them and shows each on the 7-segment
// output for a fixed hold time followed by a blank gap.
//
// state | meaning
// IDLE  | nothing to show, display blank
// LOAD  | pop FIFO head and latch its segment pattern (display blank)
// SHOW  | character visible, hold counter running
// GAP   | display blank between characters, gap counter running
module anthem_char_rx_display #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  anthem_char_rx_display_if.slave   rx_if,
  output logic [7:0]                seg_out,
  output logic                      overflow,
  output logic                      eom
);
  import anthem_pkg::*;

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  logic             strb_meta;
  logic             strb_sync;
  logic             strb_prev;
  logic             push_req;
  logic             is_nul;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       seg_reg;
  disp_state_e      state;
  disp_state_e      state_nxt;

  // Strobe synchroniser plus edge-detect flop; keeps tracking even when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_meta <= 1'b0;
      strb_sync <= 1'b0;
      strb_prev <= 1'b0;
    end else begin
      strb_meta <= rx_if.rx_strobe;
      strb_sync <= strb_meta;
      strb_prev <= strb_sync;
    end
  end

  assign push_req  = strb_sync & ~strb_prev & ena;
  assign is_nul    = (rx_if.rx_data == ASCII_NUL);
  assign eom       = push_req & is_nul;
  assign fifo_push = push_req & ~is_nul;

  anthem_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rx_if.rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Count is a register inside the FIFO, so this is registered in effect
  assign rx_if.rx_ready = ~fifo_full;

  // Sticky drop flag; a same-cycle pop frees room, so that push is not a drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  // Display FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Display FSM next-state; disabled block holds its state
  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_SHOW;
        ST_SHOW: if (cnt == '0) state_nxt = ST_GAP;
        ST_GAP:  if (cnt == '0) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Display FSM outputs; the decimal point mirrors overflow in every state
  always_comb begin
    fifo_pop = ena && (state == ST_LOAD);
    seg_out  = {overflow, (state == ST_SHOW) ? seg_reg : SEG_BLANK};
  end

  // Hold/gap down-counter and latched segment pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      seg_reg <= SEG_BLANK;
    end else if (ena) begin
      case (state)
        ST_LOAD: begin
          seg_reg <= seg_decode(fifo_dout);
          cnt     <= HOLD_LOAD;
        end
        ST_SHOW: cnt <= (cnt == '0) ? GAP_LOAD : cnt - CNT_W'(1);
        ST_GAP:  if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_anthem_char_rx_display.sv
// Directed bench for the character receiver/display.
module tb_anthem_char_rx_display;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] seg_out;
  logic       overflow;
  logic       eom;
  int         n_cmp;
  int         n_fail;

  anthem_char_rx_display_if rx_bus ();

  anthem_char_rx_display #(
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .rx_if    (rx_bus),
    .seg_out  (seg_out),
    .overflow (overflow),
    .eom      (eom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One byte: strobe high 3 cycles, low 3 cycles; period 6 cycles
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_bus.rx_data   = b;
    rx_bus.rx_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_bus.rx_strobe = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Waits for a character to appear, checks its glyph and how long it stays
  task automatic expect_char(input string tag, input logic [6:0] code,
                             input int exp_len, output int gap);
    int len;
    gap = 0;
    len = 0;
    while (seg_out[6:0] == 7'h00 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    check({tag, " code"}, 32'(seg_out[6:0]), 32'(code));
    while (seg_out[6:0] == code && len < 200) begin
      @(negedge clk);
      len++;
    end
    check({tag, " hold"}, 32'(len), 32'(exp_len));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    logic [6:0] ovf_codes [6];
    ovf_codes = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    ena = 1'b1;
    rx_bus.rx_data   = 8'h00;
    rx_bus.rx_strobe = 1'b0;

    // Reset values
    #2;
    check("rst seg_out", 32'(seg_out), 32'h00);
    check("rst rx_ready", 32'(rx_bus.rx_ready), 32'h1);
    check("rst overflow", 32'(overflow), 32'h0);
    check("rst eom", 32'(eom), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 'T': LOAD three cycles after the strobe edge, then 16 cycles of 0x78
    @(posedge clk); #1;
    rx_bus.rx_data   = 8'h54;
    rx_bus.rx_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_bus.rx_strobe = 1'b0;
    @(negedge clk);
    check("T blank before load", 32'(seg_out), 32'h00);
    check("T rx_ready", 32'(rx_bus.rx_ready), 32'h1);
    @(negedge clk);
    check("T blank in load", 32'(seg_out), 32'h00);
    @(negedge clk);
    check("T first show", 32'(seg_out), 32'h78);
    repeat (15) @(negedge clk);
    check("T last show", 32'(seg_out), 32'h78);
    @(negedge clk);
    check("T gap", 32'(seg_out), 32'h00);
    check("T rx_ready after", 32'(rx_bus.rx_ready), 32'h1);
    repeat (5) @(negedge clk);

    // 'S','O','Y' back to back; visible blank between is GAP + LOAD = 2 cycles
    fork
      begin
        send_byte(8'h53);
        send_byte(8'h4F);
        send_byte(8'h59);
      end
      begin
        expect_char("S", 7'h6D, 16, gap);
        expect_char("O", 7'h3F, 16, gap);
        check("O gap", 32'(gap), 32'd2);
        expect_char("Y", 7'h6E, 16, gap);
        check("Y gap", 32'(gap), 32'd2);
      end
    join
    repeat (5) @(negedge clk);
    check("SOY idle", 32'(seg_out), 32'h00);

    // Disabled for 200 cycles: six bytes must be ignored
    @(posedge clk); #1 ena = 1'b0;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    send_byte(8'h44); send_byte(8'h45); send_byte(8'h46);
    repeat (164) @(posedge clk);
    #1 ena = 1'b1;
    repeat (40) @(negedge clk);
    check("ena0 nothing shown", 32'(seg_out), 32'h00);
    check("ena0 rx_ready", 32'(rx_bus.rx_ready), 32'h1);

    // Stream '1'..'7': FIFO fills, '7' arrives while full and is dropped
    fork
      begin
        for (int i = 0; i < 7; i++) send_byte(8'h31 + 8'(i));
      end
      begin
        @(posedge clk);
        repeat (34) @(negedge clk);
        check("ovf full rx_ready", 32'(rx_bus.rx_ready), 32'h0);
        check("ovf before drop", 32'(overflow), 32'h0);
        repeat (5) @(negedge clk);
        check("ovf still clear", 32'(overflow), 32'h0);
        @(negedge clk);
        check("ovf set", 32'(overflow), 32'h1);
        check("ovf dp", 32'(seg_out[7]), 32'h1);
        check("ovf still full", 32'(rx_bus.rx_ready), 32'h0);
        repeat (2) @(negedge clk);
        check("ovf pop frees", 32'(rx_bus.rx_ready), 32'h1);
      end
      begin
        expect_char("ovf c1", ovf_codes[0], 16, gap);
        for (int i = 1; i < 6; i++) begin
          expect_char("ovf cn", ovf_codes[i], 16, gap);
          check("ovf cn gap", 32'(gap), 32'd2);
        end
        repeat (30) @(negedge clk);
        check("ovf dropped not shown", 32'(seg_out), 32'h80);
      end
    join

    // NUL terminator: one-cycle eom, nothing queued
    @(posedge clk); #1;
    rx_bus.rx_data   = 8'h00;
    rx_bus.rx_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("eom before", 32'(eom), 32'h0);
    @(negedge clk);
    check("eom pulse", 32'(eom), 32'h1);
    @(negedge clk);
    check("eom after", 32'(eom), 32'h0);
    @(posedge clk); #1 rx_bus.rx_strobe = 1'b0;
    repeat (15) @(negedge clk);
    check("eom no display", 32'(seg_out), 32'h80);
    check("eom rx_ready", 32'(rx_bus.rx_ready), 32'h1);

    // 'a' folds to 'A'; a 10-cycle disable mid-show stretches it to 26; '#' is a dash
    fork
      begin
        send_byte(8'h61);
        repeat (20) @(posedge clk);
        send_byte(8'h23);
      end
      begin
        expect_char("a", 7'h77, 26, gap);
        expect_char("#", 7'h40, 16, gap);
        check("# gap", 32'(gap), 32'd2);
      end
      begin
        int w;
        w = 0;
        while (seg_out[6:0] == 7'h00 && w < 100) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk); #1 ena = 1'b0;
        repeat (10) @(posedge clk);
        #1 ena = 1'b1;
      end
    join

    // Reset during SHOW of 'E' with L,L,O buffered
    repeat (5) @(negedge clk);
    fork
      begin
        send_byte(8'h48); send_byte(8'h45); send_byte(8'h4C);
        send_byte(8'h4C); send_byte(8'h4F);
      end
      begin
        @(posedge clk);
        repeat (30) @(posedge clk);
        #3;
        check("pre-rst show E", 32'(seg_out), 32'hF9);
        rst = 1'b1;
        #1;
        check("rst async seg_out", 32'(seg_out), 32'h00);
        check("rst async overflow", 32'(overflow), 32'h0);
        check("rst async rx_ready", 32'(rx_bus.rx_ready), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    check("post-rst fifo empty", 32'(seg_out), 32'h00);
    check("post-rst overflow", 32'(overflow), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
